// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and flag bit positions.
// Used by the ALU and by every stage downstream of it.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int FLG_O = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    // Overflow is only meaningful for add/sub; logic ops may leave O as junk.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_rq_fifo.sv
// Generic DEPTH-deep synchronous FIFO with a combinational head read.
// The caller qualifies push/pop against full/empty.
module alu_rq_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DW-1:0] storage [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        level_next  = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage carries no reset; stale entries are invisible once pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            storage[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = storage[rd_ptr_reg];
    assign full    = (level_reg == FULL_LEVEL);
    assign empty   = (level_reg == '0);
    assign level   = level_reg;

endmodule

// File: rtl/alu_result_queue.sv
// Registered output stage behind the combinational ALU: queues {op, flags, result},
// hands them to writeback over valid/ready, tracks sticky overflow and accepted ops.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [1:0]             CTRL,
    input  logic [W-1:0]           R,
    input  logic                   O,
    input  logic                   N,
    input  logic                   Z,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [W-1:0]           OUT_R,
    output logic [2:0]             OUT_FLAGS,
    output logic [1:0]             OUT_CTRL,
    output logic                   STICKY_O,
    input  logic                   CLR_STICKY,
    output logic [CW-1:0]          ACC_CNT,
    output logic [$clog2(DEPTH):0] LEVEL
);

    localparam int EW = W + 5;

    logic [2:0]    in_flags;
    logic [EW-1:0] wr_entry, rd_entry, head;
    logic          full, empty, push, pop;
    logic          set_sticky;
    logic          sticky_reg, sticky_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    always_comb begin
        in_flags        = '0;
        in_flags[FLG_O] = O;
        in_flags[FLG_N] = N;
        in_flags[FLG_Z] = Z;
    end

    assign wr_entry  = {CTRL, in_flags, R};
    assign IN_READY  = ~full;
    assign OUT_VALID = ~empty;
    assign push      = IN_VALID & ~full;
    assign pop       = ~empty & OUT_READY;

    alu_rq_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (LEVEL)
    );

    // Empty queue presents zeros rather than whatever the head slot last held.
    assign head      = empty ? '0 : rd_entry;
    assign OUT_R     = head[W-1:0];
    assign OUT_FLAGS = head[W+2:W];
    assign OUT_CTRL  = head[W+4:W+3];

    // A set in the same cycle as a clear must win.
    assign set_sticky  = push & O & is_arith(CTRL);
    assign sticky_next = set_sticky ? 1'b1 : (CLR_STICKY ? 1'b0 : sticky_reg);
    assign cnt_next    = push ? cnt_reg + CW'(1) : cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sticky_reg <= sticky_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign STICKY_O = sticky_reg;
    assign ACC_CNT  = cnt_reg;

endmodule
